// File: rtl/ctrl_decode_pipe_pkg.sv
// ctrl_decode_pipe_pkg: shared encodings, state type and decode table for the ID/EX control pipe
package ctrl_decode_pipe_pkg;
    typedef enum logic [1:0] {
        MODE_ARITH  = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE     = 1'b0;
    localparam state_t ST_MEM_WAIT = 1'b1;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_enable;
        logic       branch_taken;
        logic       status_we;
        logic       imm;
        logic       valid;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    function automatic ctrl_t decode(input logic [1:0] mode, input logic [3:0] opcode,
                                     input logic s, input logic imm);
        ctrl_t c;
        c = BUBBLE;
        case (mode_e'(mode))
            MODE_ARITH: begin
                c.valid     = 1'b1;
                c.imm       = imm;
                c.wb_enable = 1'b1;
                c.status_we = s;
                case (opcode)
                    OP_MOV:  c.cmd = CMD_MOV;
                    OP_MVN:  c.cmd = CMD_MVN;
                    OP_ADD:  c.cmd = CMD_ADD;
                    OP_ADC:  c.cmd = CMD_ADC;
                    OP_SUB:  c.cmd = CMD_SUB;
                    OP_SBC:  c.cmd = CMD_SBC;
                    OP_AND:  c.cmd = CMD_AND;
                    OP_ORR:  c.cmd = CMD_ORR;
                    OP_EOR:  c.cmd = CMD_EOR;
                    OP_CMP:  begin c.cmd = CMD_SUB; c.wb_enable = 1'b0; c.status_we = 1'b1; end
                    OP_TST:  begin c.cmd = CMD_AND; c.wb_enable = 1'b0; c.status_we = 1'b1; end
                    default: c = BUBBLE;
                endcase
            end
            MODE_MEM: begin
                if (opcode == OP_ADD) begin
                    c.valid     = 1'b1;
                    c.imm       = imm;
                    c.cmd       = CMD_ADD;
                    c.mem_read  = s;
                    c.mem_write = !s;
                    c.wb_enable = s;
                end
            end
            MODE_BRANCH: begin
                c.valid        = 1'b1;
                c.branch_taken = 1'b1;
            end
            default: c = BUBBLE;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/ctrl_decode_pipe_cond_check.sv
// cond_check: combinational ARM condition-field evaluation against {N,Z,C,V}
module cond_check
    import ctrl_decode_pipe_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: ID/EX control register with condition check, hazard/flush bubbles and memory-wait FSM
module ctrl_decode_pipe
    import ctrl_decode_pipe_pkg::*;
#(
    parameter int EXE_CMD_W   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [3:0]           opcode,
    input  logic                 s,
    input  logic                 imm_in,
    input  logic [3:0]           cond,
    input  logic [3:0]           nzcv,
    input  logic                 hazard,
    input  logic                 flush,
    input  logic                 mem_done,
    output logic [EXE_CMD_W-1:0] exe_cmd,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 wb_enable,
    output logic                 branch_taken,
    output logic                 status_we,
    output logic                 imm_out,
    output logic                 out_valid,
    output logic                 stall,
    output logic                 mem_timeout
);
    state_t     state;
    logic [7:0] cnt;
    logic       pass, waiting, limit;
    ctrl_t      dec, nxt, ctrl;

    cond_check u_cond (.cond(cond), .nzcv(nzcv), .pass(pass));

    assign dec         = decode(mode, opcode, s, imm_in);
    assign waiting     = state == ST_MEM_WAIT;
    assign limit       = cnt == 8'(MEM_TIMEOUT - 1);
    assign nxt         = (flush || waiting || hazard || !in_valid || !pass) ? BUBBLE : dec;
    assign stall       = waiting || hazard;
    assign mem_timeout = waiting && limit && !mem_done && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ctrl  <= BUBBLE;
        end else begin
            ctrl  <= nxt;
            state <= waiting ? ((mem_done || limit) ? ST_IDLE : ST_MEM_WAIT)
                             : ((nxt.mem_read || nxt.mem_write) ? ST_MEM_WAIT : ST_IDLE);
            cnt   <= waiting ? cnt + 8'd1 : '0;
        end
    end

    assign exe_cmd      = EXE_CMD_W'(ctrl.cmd);
    assign mem_read     = ctrl.mem_read;
    assign mem_write    = ctrl.mem_write;
    assign wb_enable    = ctrl.wb_enable;
    assign branch_taken = ctrl.branch_taken;
    assign status_we    = ctrl.status_we;
    assign imm_out      = ctrl.imm;
    assign out_valid    = ctrl.valid;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed scoreboard bench for ctrl_decode_pipe with EXE_CMD_W=6, MEM_TIMEOUT=4
module tb_ctrl_decode_pipe;
    localparam int W  = 6;
    localparam int TO = 4;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, s = 1'b0, imm_in = 1'b0;
    logic hazard = 1'b0, flush = 1'b0, mem_done = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] opcode = 4'h0, cond = 4'h0, nzcv = 4'h0;
    logic [W-1:0] exe_cmd;
    logic mem_read, mem_write, wb_enable, branch_taken, status_we, imm_out, out_valid, stall, mem_timeout;
    logic [W+6:0] obs;
    logic [W+6:0] exp_q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.EXE_CMD_W(W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .opcode(opcode), .s(s),
        .imm_in(imm_in), .cond(cond), .nzcv(nzcv), .hazard(hazard), .flush(flush),
        .mem_done(mem_done), .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
        .wb_enable(wb_enable), .branch_taken(branch_taken), .status_we(status_we),
        .imm_out(imm_out), .out_valid(out_valid), .stall(stall), .mem_timeout(mem_timeout)
    );

    assign obs = {exe_cmd, mem_read, mem_write, wb_enable, branch_taken, status_we, imm_out, out_valid};

    function automatic logic [W+6:0] model(input logic v, input logic [1:0] m, input logic [3:0] op,
                                           input logic s_, input logic i_, input logic [3:0] c,
                                           input logic [3:0] f, input logic hz, input logic fl,
                                           input logic hold);
        logic n, z, cf, vf, ok, rd, wr, wb, br, swe, im;
        logic [3:0] cmd;
        {n, z, cf, vf} = f;
        case (c)
            4'h0: ok = z;          4'h1: ok = !z;
            4'h2: ok = cf;         4'h3: ok = !cf;
            4'h4: ok = n;          4'h5: ok = !n;
            4'h6: ok = vf;         4'h7: ok = !vf;
            4'h8: ok = cf & !z;    4'h9: ok = !cf | z;
            4'hA: ok = n == vf;    4'hB: ok = n != vf;
            4'hC: ok = !z & (n == vf);
            4'hD: ok = z | (n != vf);
            4'hE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        {cmd, rd, wr, wb, br, swe, im} = '0;
        if (m == 2'b00) begin
            case (op)
                4'b1101: cmd = 4'b0001;  4'b1111: cmd = 4'b1001;
                4'b0100: cmd = 4'b0010;  4'b0101: cmd = 4'b0011;
                4'b0010: cmd = 4'b0100;  4'b0110: cmd = 4'b0101;
                4'b0000: cmd = 4'b0110;  4'b1100: cmd = 4'b0111;
                4'b0001: cmd = 4'b1000;  4'b1010: cmd = 4'b0100;
                4'b1000: cmd = 4'b0110;
                default: ok = 1'b0;
            endcase
            wb  = !(op == 4'b1010 || op == 4'b1000);
            swe = wb ? s_ : 1'b1;
            im  = i_;
        end else if (m == 2'b01) begin
            ok  = ok && op == 4'b0100;
            cmd = 4'b0010;
            rd  = s_;
            wr  = !s_;
            wb  = s_;
            im  = i_;
        end else if (m == 2'b10) begin
            br = 1'b1;
        end else begin
            ok = 1'b0;
        end
        if (!v || !ok || hz || fl || hold) return '0;
        return {W'(cmd), rd, wr, wb, br, swe, im, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            chk(tag, 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic issue(input string tag, input logic v, input logic [1:0] m, input logic [3:0] op,
                         input logic s_, input logic i_, input logic [3:0] c, input logic [3:0] f,
                         input logic hz, input logic fl, input logic md, input logic hold);
        in_valid = v; mode = m; opcode = op; s = s_; imm_in = i_; cond = c; nzcv = f;
        hazard = hz; flush = fl; mem_done = md;
        exp_q.push_back(model(v, m, op, s_, i_, c, f, hz, fl, hold));
        tick(tag);
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_outs", 32'(obs), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);
        rst = 1'b0;

        issue("add_s_al", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        chk("add_cmd", 32'(exe_cmd), 32'h02);
        issue("mov_eq_fail", 1, 2'b00, 4'b1101, 0, 0, 4'h0, 4'b0000, 0, 0, 0, 0);
        chk("mov_eq_fail_valid", 32'(out_valid), 32'd0);
        issue("mov_eq_pass", 1, 2'b00, 4'b1101, 0, 0, 4'h0, 4'b0100, 0, 0, 0, 0);
        chk("mov_eq_cmd", 32'(exe_cmd), 32'h01);
        issue("cmp", 1, 2'b00, 4'b1010, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        chk("cmp_cmd_w6", 32'(exe_cmd), 32'(6'b000100));
        issue("tst", 1, 2'b00, 4'b1000, 0, 1, 4'hE, 4'h0, 0, 0, 0, 0);
        issue("mvn_imm", 1, 2'b00, 4'b1111, 1, 1, 4'hE, 4'h0, 0, 0, 0, 0);
        issue("eor_s0", 1, 2'b00, 4'b0001, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        issue("undef_op", 1, 2'b00, 4'b0011, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        issue("mode_rsvd", 1, 2'b11, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        issue("mem_bad_op", 1, 2'b01, 4'b0101, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        issue("branch_gt", 1, 2'b10, 4'h0, 0, 1, 4'hC, 4'b1001, 0, 0, 0, 0);
        issue("branch_lt_fail", 1, 2'b10, 4'h0, 0, 0, 4'hB, 4'b1001, 0, 0, 0, 0);
        issue("not_valid", 0, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++)
            issue("cond_sweep", 1, 2'b00, 4'b1101, 1, 0, 4'(k), 4'($urandom_range(0, 15)), 0, 0, 0, 0);
        for (int k = 0; k < 12; k++)
            issue("rand_decode", 1, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 0, 0, 0, 0);

        issue("hazard", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 1, 0, 0, 0);
        chk("hazard_stall", 32'(stall), 32'd1);
        issue("hazard_flush", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 1, 1, 0, 0);
        chk("hazard_flush_stall", 32'(stall), 32'd1);
        issue("flush", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 1, 0, 0);
        chk("flush_stall", 32'(stall), 32'd0);

        issue("ldr", 1, 2'b01, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        chk("ldr_stall", 32'(stall), 32'd1);
        issue("ldr_wait1", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        chk("ldr_wait2_stall", 32'(stall), 32'd1);
        issue("ldr_wait2_flush", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 1, 0, 1);
        chk("ldr_wait3_stall", 32'(stall), 32'd1);
        issue("ldr_wait3_done", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 1, 1);
        chk("ldr_done_stall", 32'(stall), 32'd0);
        chk("ldr_done_no_timeout", 32'(mem_timeout), 32'd0);
        issue("idle_done_ignored", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 1, 0);
        chk("idle_done_stall", 32'(stall), 32'd0);

        issue("str", 1, 2'b01, 4'b0100, 0, 1, 4'hE, 4'h0, 0, 0, 0, 0);
        chk("str_wc1_timeout", 32'(mem_timeout), 32'd0);
        issue("str_wc1", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        chk("str_wc2_timeout", 32'(mem_timeout), 32'd0);
        issue("str_wc2", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        chk("str_wc3_timeout", 32'(mem_timeout), 32'd0);
        issue("str_wc3", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        chk("str_wc4_timeout", 32'(mem_timeout), 32'd1);
        chk("str_wc4_stall", 32'(stall), 32'd1);
        issue("str_wc4", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        chk("str_after_timeout", 32'(mem_timeout), 32'd0);
        chk("str_after_stall", 32'(stall), 32'd0);
        issue("post_timeout_add", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);

        issue("str2", 1, 2'b01, 4'b0100, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        for (int k = 0; k < TO - 1; k++)
            issue("str2_wait", 0, 2'b00, 4'h0, 0, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        mem_done = 1'b1;
        #1;
        chk("done_at_limit_timeout", 32'(mem_timeout), 32'd0);
        issue("str2_done_at_limit", 0, 2'b00, 4'h0, 0, 0, 4'hE, 4'h0, 0, 0, 1, 1);
        chk("done_at_limit_stall", 32'(stall), 32'd0);

        issue("ldr_rst", 1, 2'b01, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 0);
        issue("ldr_rst_wait1", 0, 2'b00, 4'h0, 0, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        rst = 1'b1;
        issue("rst_mid_wait", 1, 2'b00, 4'b0100, 1, 0, 4'hE, 4'h0, 0, 0, 0, 1);
        rst = 1'b0;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_timeout", 32'(mem_timeout), 32'd0);
        for (int k = 0; k < 3; k++) begin
            issue("post_rst_idle", 0, 2'b00, 4'h0, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0);
            chk("post_rst_no_timeout", 32'(mem_timeout), 32'd0);
        end
        issue("post_rst_add", 1, 2'b00, 4'b0100, 0, 1, 4'hE, 4'h0, 0, 0, 0, 0);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
